// File: rtl/param_updown_counter.sv
// Registered up/down counter with step, load, modulo limit,
// wrap/saturate mode, terminal-count and over/underflow pulses.
module param_updown_counter #(
  parameter int WIDTH   = 4,
  parameter int STEP_W  = 2,
  parameter int RST_VAL = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              up_dn,
  input  logic [STEP_W-1:0] step,
  input  logic [WIDTH-1:0]  limit,
  input  logic              sat,
  input  logic              ld,
  input  logic [WIDTH-1:0]  ld_val,
  output logic [WIDTH-1:0]  count,
  output logic              tc,
  output logic              ovf,
  output logic              unf
);

  localparam logic [WIDTH-1:0] RST_C = WIDTH'(RST_VAL);

  logic [WIDTH:0]   c_x;
  logic [WIDTH:0]   s_x;
  logic [WIDTH:0]   l_x;
  logic [WIDTH:0]   lp1;
  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   dif;
  logic             big;
  logic [WIDTH-1:0] nxt;
  logic             nov;
  logic             nun;

  // Operands widened by one bit so carries and borrows are visible.
  always_comb begin
    c_x = {1'b0, count};
    s_x = (WIDTH+1)'(step);
    l_x = {1'b0, limit};
    lp1 = l_x + 1'b1;
    sum = c_x + s_x;
    dif = s_x - c_x;
    big = s_x > lp1;
  end

  // Next count and crossing flags: load beats enable beats hold.
  always_comb begin
    nxt = count;
    nov = 1'b0;
    nun = 1'b0;
    if (ld) begin
      nxt = (ld_val > limit) ? limit : ld_val;
    end else if (en && (step != '0)) begin
      if (up_dn) begin
        if (c_x > l_x) begin
          nov = 1'b1;
          if (sat || big) nxt = limit;
          else            nxt = WIDTH'(s_x - 1'b1);
        end else if (sum > l_x) begin
          nov = 1'b1;
          if (sat || big) nxt = limit;
          else            nxt = WIDTH'(sum - lp1);
        end else begin
          nxt = WIDTH'(sum);
        end
      end else begin
        if (s_x > c_x) begin
          nun = 1'b1;
          if (sat)      nxt = '0;
          else if (big) nxt = limit;
          else          nxt = WIDTH'(lp1 - dif);
        end else begin
          nxt = WIDTH'(c_x - s_x);
        end
      end
    end
  end

  // Count and flag registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count <= RST_C;
      ovf   <= 1'b0;
      unf   <= 1'b0;
    end else begin
      count <= nxt;
      ovf   <= nov;
      unf   <= nun;
    end
  end

  // Terminal count follows direction; held low while in reset.
  always_comb begin
    tc = 1'b0;
    if (rst_n) begin
      tc = up_dn ? (count == limit) : (count == '0);
    end
  end

endmodule

// File: tb/tb_param_updown_counter.sv
// Randomised scoreboard bench for param_updown_counter
// against an arithmetic reference model.
module tb_param_updown_counter;

  localparam int W  = 4;
  localparam int SW = 2;
  localparam int RV = 3;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          en;
  logic          up_dn;
  logic [SW-1:0] step;
  logic [W-1:0]  limit;
  logic          sat;
  logic          ld;
  logic [W-1:0]  ld_val;
  logic [W-1:0]  count;
  logic          tc;
  logic          ovf;
  logic          unf;

  param_updown_counter #(
    .WIDTH(W), .STEP_W(SW), .RST_VAL(RV)
  ) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .up_dn(up_dn),
    .step(step), .limit(limit), .sat(sat), .ld(ld),
    .ld_val(ld_val), .count(count), .tc(tc),
    .ovf(ovf), .unf(unf)
  );

  always #5 clk = ~clk;

  typedef struct {
    int id;
    int c;
    bit o;
    bit u;
    bit t;
  } exp_t;

  exp_t q[$];
  int   errors = 0;
  int   checks = 0;
  int   mc     = 0;
  int   txn    = 0;

  // Reference: plain integer arithmetic on the counter rules.
  task automatic drive(input bit r, input bit l, input int lv,
                       input bit e, input bit u, input int s,
                       input int lm, input bit sa);
    exp_t x;
    bit   o = 0;
    bit   un = 0;
    @(negedge clk);
    rst_n  = r;
    ld     = l;
    ld_val = W'(lv);
    en     = e;
    up_dn  = u;
    step   = SW'(s);
    limit  = W'(lm);
    sat    = sa;
    if (!r) begin
      mc = RV;
    end else if (l) begin
      mc = (lv > lm) ? lm : lv;
    end else if (e && s != 0) begin
      if (u) begin
        if (mc > lm) begin
          o  = 1;
          mc = (sa || s > lm + 1) ? lm : s - 1;
        end else if (mc + s > lm) begin
          o  = 1;
          mc = (sa || s > lm + 1) ? lm : (mc + s) % (lm + 1);
        end else begin
          mc = mc + s;
        end
      end else begin
        if (s > mc) begin
          un = 1;
          if (sa)              mc = 0;
          else if (s > lm + 1) mc = lm;
          else                 mc = lm + 1 - (s - mc);
        end else begin
          mc = mc - s;
        end
      end
    end
    x.id = txn;
    x.c  = mc;
    x.o  = o;
    x.u  = un;
    x.t  = r && (u ? (mc == lm) : (mc == 0));
    q.push_back(x);
    txn++;
  endtask

  // Monitor: every edge that had stimulus yields one response.
  initial begin
    exp_t x;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() != 0) begin
        x = q.pop_front();
        checks++;
        if (int'(count) !== x.c || ovf !== x.o ||
            unf !== x.u || tc !== x.t) begin
          errors++;
          $display("FAIL txn%0d: count=%0d ovf=%b unf=%b tc=%b, expected count=%0d ovf=%b unf=%b tc=%b",
                   x.id, count, ovf, unf, tc,
                   x.c, x.o, x.u, x.t);
        end
      end
    end
  end

  initial begin
    int lm;
    rst_n = 0; ld = 0; ld_val = 0; en = 0; up_dn = 1;
    step = 0; limit = 15; sat = 0;
    // reset with load and enable active
    drive(0, 1, 9, 1, 1, 1, 15, 0);
    drive(0, 1, 9, 1, 1, 1, 15, 0);
    // resume counting from reset value
    repeat (3) drive(1, 0, 0, 1, 1, 1, 15, 0);
    // wrap up through limit 9
    drive(1, 1, 0, 0, 1, 1, 9, 0);
    repeat (12) drive(1, 0, 0, 1, 1, 1, 9, 0);
    // saturate down by 2
    drive(1, 1, 5, 0, 0, 2, 15, 1);
    repeat (4) drive(1, 0, 0, 1, 0, 2, 15, 1);
    // wrap down by 3
    drive(1, 1, 1, 0, 0, 3, 9, 0);
    drive(1, 0, 0, 1, 0, 3, 9, 0);
    drive(1, 0, 0, 0, 0, 3, 9, 0);
    // load clamp beats enable; reset beats load
    drive(1, 1, 12, 1, 1, 1, 9, 0);
    drive(0, 1, 12, 1, 1, 1, 9, 0);
    // limit dropped below count
    drive(1, 1, 14, 0, 1, 1, 15, 1);
    drive(1, 0, 0, 1, 1, 1, 5, 1);
    drive(1, 1, 14, 0, 1, 1, 15, 0);
    drive(1, 0, 0, 1, 1, 1, 5, 0);
    // step of zero holds
    drive(1, 0, 0, 1, 1, 0, 5, 0);
    // oversized step under tiny limits
    drive(1, 1, 1, 0, 1, 3, 1, 0);
    drive(1, 0, 0, 1, 1, 3, 1, 0);
    drive(1, 0, 0, 1, 0, 3, 1, 0);
    drive(1, 0, 0, 1, 1, 2, 0, 0);
    // randomised traffic
    lm = 9;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 19) == 0) lm = $urandom_range(0, 15);
      drive($urandom_range(0, 49) != 0,
            $urandom_range(0, 9) == 0,
            $urandom_range(0, 15),
            $urandom_range(0, 3) != 0,
            1'($urandom),
            $urandom_range(0, 3),
            lm,
            1'($urandom));
    end
    @(negedge clk);
    en = 0;
    ld = 0;
    for (int i = 0; i < 10 && q.size() != 0; i++) @(negedge clk);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: pending=%0d, expected 0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
